hazard_unit: RTL

Pipeline hazard controller for the 4-stage RV32I core (IF, ID, EX, MEM/WB). It tracks destination registers of the instructions in EX and MEM, and drives the `idecode` operand-forwarding selects. It also generates load-use stalls, branch flushes and data-memory freezes, and counts lost cycles for performance monitoring. It sits beside `idecode` and sequences the IF/ID and ID/EX pipeline registers.

---
 rtl/hazard_unit_pkg.sv | 46 ++++
 rtl/hazard_unit_if.sv | 29 ++
 rtl/hazard_unit_operand_usage.sv | 22 ++
 rtl/hazard_unit.sv | 109 ++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared RV32I opcode constants, hazard slot layout and forwarding select
// encodings for the pipeline hazard controller.
package hazard_unit_pkg;

    localparam int NB_WORD    = 32;
    localparam int NB_OPERAND = 5;
    localparam int NB_COUNT   = 32;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_ALU = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // rd is stored as 0 for non-writers, so "writer" reduces to valid && rd != 0.
    typedef struct packed {
        logic                  valid;
        logic [NB_OPERAND-1:0] rd;
        logic                  is_load;
        logic                  is_mem;
    } hazard_slot_t;

    function automatic logic [1:0] fwd_select(input hazard_slot_t ex,
                                              input hazard_slot_t mem,
                                              input logic [NB_OPERAND-1:0] rs,
                                              input logic used);
        logic [1:0] sel;
        sel = FWD_RF;
        if (used && ex.valid && !ex.is_load && (ex.rd != '0) && (ex.rd == rs))
            sel = FWD_ALU;
        else if (used && mem.valid && (mem.rd != '0) && (mem.rd == rs))
            sel = FWD_MEM;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard controller bus: ID-stage inputs and pipeline control outputs.
interface hazard_unit_if;
    import hazard_unit_pkg::*;

    logic                i_id_valid;
    logic [NB_WORD-1:0]  i_id_instruction;
    logic                i_branch_taken;
    logic                i_mem_ready;
    logic [1:0]          o_forward_rs1;
    logic [1:0]          o_forward_rs2;
    logic                o_stall_if;
    logic                o_stall_id;
    logic                o_bubble_ex;
    logic                o_flush_id;
    logic                o_freeze;
    logic [NB_COUNT-1:0] o_stall_count;

    modport master (
        output i_id_valid, i_id_instruction, i_branch_taken, i_mem_ready,
        input  o_forward_rs1, o_forward_rs2, o_stall_if, o_stall_id,
               o_bubble_ex, o_flush_id, o_freeze, o_stall_count
    );

    modport slave (
        input  i_id_valid, i_id_instruction, i_branch_taken, i_mem_ready,
        output o_forward_rs1, o_forward_rs2, o_stall_if, o_stall_id,
               o_bubble_ex, o_flush_id, o_freeze, o_stall_count
    );
endinterface

// File: rtl/hazard_unit_operand_usage.sv
// Opcode decode of register usage and memory class for the ID instruction.
module operand_usage
    import hazard_unit_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic       o_uses_rs1,
    output logic       o_uses_rs2,
    output logic       o_writes_rd,
    output logic       o_is_load,
    output logic       o_is_mem
);
    always_comb begin
        o_uses_rs1  = !((i_opcode == OPC_LUI) || (i_opcode == OPC_AUIPC) ||
                        (i_opcode == OPC_JAL));
        o_uses_rs2  = (i_opcode == OPC_OP) || (i_opcode == OPC_STORE) ||
                      (i_opcode == OPC_BRANCH);
        o_writes_rd = !((i_opcode == OPC_STORE) || (i_opcode == OPC_BRANCH) ||
                        (i_opcode == OPC_MISC_MEM) || (i_opcode == OPC_SYSTEM));
        o_is_load   = (i_opcode == OPC_LOAD);
        o_is_mem    = (i_opcode == OPC_LOAD) || (i_opcode == OPC_STORE);
    end
endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, load-use stall, branch
// flush, data-memory freeze and a saturating lost-cycle counter.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic          i_clock,
    input  logic          i_reset,
    hazard_unit_if.slave  bus
);
    hazard_slot_t          r_ex;
    hazard_slot_t          r_mem;
    logic [NB_COUNT-1:0]   r_count;

    logic [6:0]            w_opcode;
    logic [NB_OPERAND-1:0] w_rd;
    logic [NB_OPERAND-1:0] w_rs1;
    logic [NB_OPERAND-1:0] w_rs2;
    logic                  w_uses_rs1;
    logic                  w_uses_rs2;
    logic                  w_writes_rd;
    logic                  w_is_load;
    logic                  w_is_mem;
    logic                  w_use1;
    logic                  w_use2;
    logic                  w_load_use;
    logic                  w_freeze;
    logic                  w_branch;
    logic                  w_stall;
    hazard_slot_t          w_id_slot;
    logic                  w_unused_bits;

    assign w_opcode      = bus.i_id_instruction[6:0];
    assign w_rd          = bus.i_id_instruction[11:7];
    assign w_rs1         = bus.i_id_instruction[19:15];
    assign w_rs2         = bus.i_id_instruction[24:20];
    assign w_unused_bits = ^{bus.i_id_instruction[31:25], bus.i_id_instruction[14:12]};

    operand_usage u_operand_usage (
        .i_opcode    (w_opcode),
        .o_uses_rs1  (w_uses_rs1),
        .o_uses_rs2  (w_uses_rs2),
        .o_writes_rd (w_writes_rd),
        .o_is_load   (w_is_load),
        .o_is_mem    (w_is_mem)
    );

    assign w_use1 = bus.i_id_valid && w_uses_rs1;
    assign w_use2 = bus.i_id_valid && w_uses_rs2;

    assign w_load_use = r_ex.valid && r_ex.is_load && (r_ex.rd != '0) &&
                        ((w_use1 && (w_rs1 == r_ex.rd)) || (w_use2 && (w_rs2 == r_ex.rd)));
    assign w_freeze   = r_mem.valid && r_mem.is_mem && !bus.i_mem_ready;
    // A frozen EX still holds the branch; it re-asserts once the freeze lifts.
    assign w_branch   = bus.i_branch_taken && !w_freeze;
    assign w_stall    = w_load_use && !w_freeze && !w_branch;

    always_comb begin
        w_id_slot         = '0;
        w_id_slot.valid   = 1'b1;
        w_id_slot.rd      = w_writes_rd ? w_rd : '0;
        w_id_slot.is_load = w_is_load;
        w_id_slot.is_mem  = w_is_mem;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ex  <= '0;
            r_mem <= '0;
        end else if (!w_freeze) begin
            r_mem <= r_ex;
            r_ex  <= (bus.i_id_valid && !w_branch && !w_stall) ? w_id_slot : '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_count <= '0;
        else if ((w_stall || w_freeze) && (r_count != '1))
            r_count <= r_count + 1'b1;
    end

    always_comb begin
        bus.o_forward_rs1 = FWD_RF;
        bus.o_forward_rs2 = FWD_RF;
        bus.o_stall_if    = 1'b0;
        bus.o_stall_id    = 1'b0;
        bus.o_bubble_ex   = 1'b0;
        bus.o_flush_id    = 1'b0;
        bus.o_freeze      = 1'b0;
        bus.o_stall_count = '0;
        if (!i_reset) begin
            bus.o_forward_rs1 = fwd_select(r_ex, r_mem, w_rs1, w_use1);
            bus.o_forward_rs2 = fwd_select(r_ex, r_mem, w_rs2, w_use2);
            bus.o_stall_count = r_count;
            if (w_freeze) begin
                bus.o_freeze   = 1'b1;
                bus.o_stall_if = 1'b1;
                bus.o_stall_id = 1'b1;
            end else if (w_branch) begin
                bus.o_flush_id  = 1'b1;
                bus.o_bubble_ex = 1'b1;
            end else if (w_stall) begin
                bus.o_stall_if  = 1'b1;
                bus.o_stall_id  = 1'b1;
                bus.o_bubble_ex = 1'b1;
            end
        end
    end
endmodule
